// File: rtl/fsic_io_serdes_tx.sv
// FSIC serial-link transmitter: 2-deep frame FIFO feeding a per-phase lane serializer on ioclk.
// Optional FSIC_SERDES_TX_IDLE_HOLD_EN: idle frames repeat the last data frame with tvalid cleared.
module fsic_io_serdes_tx #(
  parameter int pSERIALIO_WIDTH = 12,
  parameter int pCLK_RATIO      = 4,
  parameter int pVALID_BIT      = 45,
  parameter int pREADY_BIT      = 44
) (
  input  logic                                  ioclk,
  input  logic                                  axis_rst_n,
  input  logic                                  tx_en_req,
  input  logic                                  phase_sync,
  input  logic                                  local_tready,
  input  logic [pSERIALIO_WIDTH*pCLK_RATIO-1:0] in_word,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [pSERIALIO_WIDTH-1:0]            serial_txd,
  output logic                                  tx_active,
  output logic [15:0]                           frame_cnt
);

  localparam int pFRAME_WIDTH = pSERIALIO_WIDTH * pCLK_RATIO;
  localparam int pPHASE_W     = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
  localparam logic [pPHASE_W-1:0] pLAST_PHASE = pPHASE_W'(pCLK_RATIO - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [pPHASE_W-1:0]      phase_q, phase_d;
  logic [pFRAME_WIDTH-1:0]  frame_q, frame_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic [pFRAME_WIDTH-1:0]  fifo_mem_q [2];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;

`ifdef FSIC_SERDES_TX_IDLE_HOLD_EN
  logic [pFRAME_WIDTH-1:0]  last_data_q, last_data_d;
`endif

  logic                     running;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     push;
  logic                     pop;
  logic                     arm_start;
  logic                     boundary;
  logic                     load;
  logic [pFRAME_WIDTH-1:0]  idle_frame;
  logic [pFRAME_WIDTH-1:0]  load_frame;

  // ---------------------------------------------------------------------
  // Status decode
  // ---------------------------------------------------------------------
  assign running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign in_ready   = !fifo_full && ((state_q == ST_ARM) || (state_q == ST_RUN));
  assign push       = in_valid && in_ready;
  assign arm_start  = (state_q == ST_ARM) && tx_en_req && phase_sync;
  assign boundary   = running && (phase_q == pLAST_PHASE);
  // Occupancy is taken before this edge's push, so a word never bypasses the FIFO.
  assign load       = boundary || arm_start;
  assign pop        = load && !fifo_empty;

  assign tx_active  = running;
  assign frame_cnt  = frame_cnt_q;

  // ---------------------------------------------------------------------
  // Frame selection
  // ---------------------------------------------------------------------
  always_comb begin
    idle_frame = '0;
`ifdef FSIC_SERDES_TX_IDLE_HOLD_EN
    idle_frame = last_data_q;
`endif
    idle_frame[pVALID_BIT] = 1'b0;

    load_frame = fifo_empty ? idle_frame : fifo_mem_q[rd_ptr_q];
    // The flow-control bit always reflects the receiver state at load time.
    load_frame[pREADY_BIT] = local_tready;
  end

  // ---------------------------------------------------------------------
  // Control FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_en_req) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!tx_en_req)     state_d = ST_IDLE;
        else if (phase_sync) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!tx_en_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tx_en_req)                   state_d = ST_RUN;
        else if (boundary && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Phase, frame register and frame counter
  // ---------------------------------------------------------------------
  always_comb begin
    phase_d     = phase_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;

    if (arm_start) begin
      phase_d = '0;
    end else if (running) begin
      phase_d = (phase_q == pLAST_PHASE) ? '0 : phase_q + pPHASE_W'(1);
    end

    if (load) frame_d = load_frame;
    if (pop)  frame_cnt_d = frame_cnt_q + 16'd1;
  end

`ifdef FSIC_SERDES_TX_IDLE_HOLD_EN
  always_comb begin
    last_data_d = last_data_q;
    if (pop) last_data_d = load_frame;
  end
`endif

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
    end else if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_word;
    end
  end

`ifdef FSIC_SERDES_TX_IDLE_HOLD_EN
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) last_data_q <= '0;
    else             last_data_q <= last_data_d;
  end
`endif

  // ---------------------------------------------------------------------
  // Lane serializer: lane j carries frame bits j*pCLK_RATIO .. +pCLK_RATIO-1
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < pSERIALIO_WIDTH; gi++) begin : g_lane
      logic [pCLK_RATIO-1:0] lane_bits;
      assign lane_bits      = frame_q[gi*pCLK_RATIO +: pCLK_RATIO];
      assign serial_txd[gi] = lane_bits[phase_q] & tx_active;
    end
  endgenerate

endmodule
